// File: rtl/mem_stage_hs_if.sv
// mem_stage_hs_if: req/gnt/rvalid data-memory bus between the MEM stage (master) and memory (slave)
// mem_req/mem_addr/mem_we/mem_be/mem_wd go to memory; mem_gnt/mem_rvalid/mem_rdata come back.
interface mem_stage_hs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  modport master (output mem_req, mem_addr, mem_we, mem_be, mem_wd, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input mem_req, mem_addr, mem_we, mem_be, mem_wd, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MIPS MEM stage with sized loads/stores over a req/gnt/rvalid memory bus
// Ports: clk, rst_n (async active-low); EX/MEM controls RegWriteM, MemtoRegM, MemWriteM, MemSizeM,
// MemSignedM, ALUDataM, WriteDataM, WriteRegM; bus (memory master modport); stall_o holds upstream;
// misalign_o flags bad accesses; bus_err_o pulses on timeout; RegWriteM_o/WriteRegData/WriteRegAddr to WB.
module mem_stage_hs #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [1:0]        MemSizeM,
  input  logic              MemSignedM,
  input  logic [DATA_W-1:0] ALUDataM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_AW-1:0] WriteRegM,
  mem_stage_hs_if.master    bus,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              RegWriteM_o,
  output logic [DATA_W-1:0] WriteRegData,
  output logic [REG_AW-1:0] WriteRegAddr
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, FIN} stateT;
  stateT                     state;
  logic [7:0]                waitCnt;
  logic [DATA_W-1:0]         rdataQ;
  logic                      errQ;
  logic                      access, bad, isLoad, start, timeout;
  logic [OFF_W-1:0]          off;
  logic [NB-1:0]             beBase;
  logic [6:0]                extAmt;
  logic [DATA_W-1:0]         shifted, aligned, loadExt;
  logic signed [DATA_W-1:0]  sext;
  assign isLoad = MemtoRegM;
  assign access = MemtoRegM | MemWriteM;
  assign off    = ALUDataM[OFF_W-1:0];
  assign bad    = (DATA_W == 32 && MemSizeM == 2'd3) ||
                  (MemSizeM == 2'd1 && ALUDataM[0]) ||
                  (MemSizeM == 2'd2 && ALUDataM[1:0] != 2'd0) ||
                  (MemSizeM == 2'd3 && ALUDataM[2:0] != 3'd0);
  assign start  = state == IDLE && access && !bad;
  assign timeout = waitCnt == 8'(MAX_WAIT - 1) &&
                   ((state == REQ && !bus.mem_gnt) || (state == WAIT_R && !bus.mem_rvalid));
  assign beBase = MemSizeM == 2'd0 ? NB'(1) : MemSizeM == 2'd1 ? NB'(3) : NB'(15);
  assign bus.mem_be   = MemSizeM == 2'd3 ? '1 : beBase << off;
  // Aligned accesses make "shift into lane, replicate below" equal to plain replication of the datum.
  assign bus.mem_wd   = MemSizeM == 2'd0 ? {NB{WriteDataM[7:0]}} :
                        MemSizeM == 2'd1 ? {(NB/2){WriteDataM[15:0]}} :
                        MemSizeM == 2'd2 ? {(NB/4){WriteDataM[31:0]}} : WriteDataM;
  assign bus.mem_addr = {ALUDataM[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign bus.mem_we   = !isLoad;
  assign bus.mem_req  = rst_n && (start || state == REQ);
  // Extension: move the selected lanes to the top, then shift back arithmetically or logically.
  assign shifted = bus.mem_rdata >> {off, 3'b000};
  assign extAmt  = MemSizeM == 2'd3 ? 7'd0 : 7'(DATA_W - (8 << MemSizeM));
  assign aligned = shifted << extAmt;
  assign sext    = $signed(aligned) >>> extAmt;
  assign loadExt = MemSignedM ? $unsigned(sext) : aligned >> extAmt;
  assign stall_o      = rst_n && (start || state == REQ || state == WAIT_R);
  assign misalign_o   = rst_n && state == IDLE && access && bad;
  assign bus_err_o    = timeout;
  assign RegWriteM_o  = rst_n && (state == IDLE ? RegWriteM && !access
                                                : state == FIN && isLoad && !errQ && RegWriteM);
  assign WriteRegData = state == FIN ? rdataQ : ALUDataM;
  assign WriteRegAddr = WriteRegM;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      waitCnt <= '0;
      rdataQ  <= '0;
      errQ    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          waitCnt <= '0;
          errQ    <= 1'b0;
          if (start) state <= bus.mem_gnt ? (isLoad ? WAIT_R : FIN) : REQ;
        end
        REQ: begin
          waitCnt <= bus.mem_gnt ? 8'd0 : waitCnt + 8'd1;
          errQ    <= timeout;
          if (bus.mem_gnt) state <= isLoad ? WAIT_R : FIN;
          else if (timeout) state <= FIN;
        end
        WAIT_R: begin
          waitCnt <= waitCnt + 8'd1;
          errQ    <= timeout;
          if (bus.mem_rvalid) begin
            rdataQ <= loadExt;
            state  <= FIN;
          end else if (timeout) state <= FIN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: randomized and directed checks of mem_stage_hs against an arithmetic reference model
module tb_mem_stage_hs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWriteM = 1'b0, MemtoRegM = 1'b0, MemWriteM = 1'b0, MemSignedM = 1'b0;
  logic [1:0]  MemSizeM = 2'd0;
  logic [31:0] ALUDataM = '0, WriteDataM = '0;
  logic [4:0]  WriteRegM = '0;
  logic        stall_o, misalign_o, bus_err_o, RegWriteM_o;
  logic [31:0] WriteRegData;
  logic [4:0]  WriteRegAddr;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_stage_hs_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  mem_stage_hs #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .MemSizeM(MemSizeM), .MemSignedM(MemSignedM), .ALUDataM(ALUDataM), .WriteDataM(WriteDataM),
    .WriteRegM(WriteRegM), .bus(bus), .stall_o(stall_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o), .RegWriteM_o(RegWriteM_o), .WriteRegData(WriteRegData),
    .WriteRegAddr(WriteRegAddr)
  );
  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
    int n;
    n = 1 << size;
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction
  function automatic logic [31:0] model_wd(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] r;
    int n;
    n = 1 << size;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = data[8*(i % n) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] model_load(input logic [1:0] size, input bit sgn, input logic [31:0] addr, input logic [31:0] rdata);
    longint unsigned v, mask;
    int bits;
    bits = 8 << size;
    v = 64'(rdata) >> (8 * (addr % 4));
    mask = (64'd1 << bits) - 1;
    v = v & mask;
    if (sgn && v[bits-1]) v = v | ~mask;
    return v[31:0];
  endfunction
  function automatic bit model_bad(input logic [1:0] size, input logic [31:0] addr);
    return size == 2'd3 || (addr % (1 << size)) != 0;
  endfunction
  task automatic clear_inputs();
    MemtoRegM = 1'b0; MemWriteM = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
  endtask
  task automatic run_access(input bit load, input logic [1:0] size, input bit sgn, input bit rw,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                            input int gd, input int rd, input bit noise, output logic [31:0] got);
    int last;
    bit inReq, fin, expRw;
    last = load ? gd + rd + 2 : gd + 1;
    got = '0;
    RegWriteM = rw; MemtoRegM = load; MemWriteM = !load; MemSizeM = size; MemSignedM = sgn;
    ALUDataM = addr; WriteDataM = wdata; WriteRegM = 5'($urandom);
    for (int c = 0; c <= last; c++) begin
      bus.mem_gnt = c == gd;
      bus.mem_rvalid = (load && c == gd + 1 + rd) || (noise && c == gd);
      bus.mem_rdata = (load && c == gd + 1 + rd) ? rdata : $urandom;
      inReq = c <= gd;
      fin = c == last;
      expRw = fin && load && rw;
      @(negedge clk);
      checks++;
      if (bus.mem_req !== inReq || stall_o !== !fin || RegWriteM_o !== expRw || bus_err_o !== 1'b0)
        begin errors++; $display("FAIL access_ctrl cycle %0d: req=%b stall=%b rwo=%b err=%b expected req=%b stall=%b rwo=%b err=0",
          c, bus.mem_req, stall_o, RegWriteM_o, bus_err_o, inReq, !fin, expRw); end
      if (inReq) begin
        checks++;
        if ({bus.mem_addr, bus.mem_be, bus.mem_wd, bus.mem_we} !== {addr & 32'hFFFF_FFFC, model_be(size, addr), model_wd(size, wdata), !load})
          begin errors++; $display("FAIL access_bus cycle %0d: addr=%h be=%b wd=%h we=%b expected addr=%h be=%b wd=%h we=%b",
            c, bus.mem_addr, bus.mem_be, bus.mem_wd, bus.mem_we, addr & 32'hFFFF_FFFC, model_be(size, addr), model_wd(size, wdata), !load); end
      end
      if (fin && load) begin
        got = WriteRegData;
        checks++;
        if (WriteRegData !== model_load(size, sgn, addr, rdata) || WriteRegAddr !== WriteRegM)
          begin errors++; $display("FAIL load_data: got %h/%0d expected %h/%0d", WriteRegData, WriteRegAddr,
            model_load(size, sgn, addr, rdata), WriteRegM); end
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask
  task automatic test_reset();
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemSizeM = 2'd2; ALUDataM = 32'h100;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, stall_o, misalign_o, RegWriteM_o, bus_err_o} !== 5'b0)
      begin errors++; $display("FAIL reset_outputs: req/stall/mis/rwo/err=%b expected 00000",
        {bus.mem_req, stall_o, misalign_o, RegWriteM_o, bus_err_o}); end
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || stall_o !== 1'b0 || WriteRegData !== 32'h100)
      begin errors++; $display("FAIL reset_idle: req=%b stall=%b wrd=%h expected 0 0 00000100", bus.mem_req, stall_o, WriteRegData); end
    @(posedge clk); #1;
  endtask
  task automatic test_passthrough();
    for (int i = 0; i < 6; i++) begin
      RegWriteM = i == 0 ? 1'b1 : 1'($urandom);
      ALUDataM = i == 0 ? 32'h1234 : $urandom;
      WriteRegM = 5'($urandom);
      @(negedge clk);
      checks++;
      if (WriteRegData !== ALUDataM || RegWriteM_o !== RegWriteM || stall_o !== 1'b0 || bus.mem_req !== 1'b0 || WriteRegAddr !== WriteRegM)
        begin errors++; $display("FAIL passthrough %0d: wrd=%h rwo=%b stall=%b req=%b expected wrd=%h rwo=%b stall=0 req=0",
          i, WriteRegData, RegWriteM_o, stall_o, bus.mem_req, ALUDataM, RegWriteM); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_store_byte();
    RegWriteM = 1'b1; MemWriteM = 1'b1; MemSizeM = 2'd0; ALUDataM = 32'h103; WriteDataM = 32'hAB;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_be !== 4'b1000 || bus.mem_wd[31:24] !== 8'hAB || bus.mem_addr !== 32'h100 || stall_o !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1)
      begin errors++; $display("FAIL store_byte_req: be=%b wd=%h addr=%h stall=%b req=%b expected be=1000 wd=AB...... addr=00000100 stall=1 req=1",
        bus.mem_be, bus.mem_wd, bus.mem_addr, stall_o, bus.mem_req); end
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b0 || RegWriteM_o !== 1'b0 || bus.mem_req !== 1'b0)
      begin errors++; $display("FAIL store_byte_fin: stall=%b rwo=%b req=%b expected 0 0 0", stall_o, RegWriteM_o, bus.mem_req); end
    @(posedge clk); #1;
    clear_inputs();
  endtask
  task automatic test_load_half();
    logic [31:0] got;
    run_access(1'b1, 2'd1, 1'b1, 1'b1, 32'h202, 32'h0, 32'h8001_0000, 2, 2, 1'b0, got);
    checks++;
    if (got !== 32'hFFFF_8001) begin errors++; $display("FAIL load_half_signed: got %h expected ffff8001", got); end
    run_access(1'b1, 2'd1, 1'b0, 1'b1, 32'h202, 32'h0, 32'h8001_0000, 2, 2, 1'b0, got);
    checks++;
    if (got !== 32'h0000_8001) begin errors++; $display("FAIL load_half_unsigned: got %h expected 00008001", got); end
  endtask
  task automatic test_misalign();
    logic [1:0]  sizes [4] = '{2'd2, 2'd1, 2'd2, 2'd3};
    logic [31:0] addrs [4] = '{32'h101, 32'h203, 32'h102, 32'h100};
    for (int i = 0; i < 4; i++) begin
      RegWriteM = 1'b1; MemtoRegM = i[0]; MemWriteM = !i[0]; MemSizeM = sizes[i]; ALUDataM = addrs[i];
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      checks++;
      if (misalign_o !== 1'b1 || bus.mem_req !== 1'b0 || RegWriteM_o !== 1'b0 || stall_o !== 1'b0)
        begin errors++; $display("FAIL misalign %0d: mis=%b req=%b rwo=%b stall=%b expected 1 0 0 0",
          i, misalign_o, bus.mem_req, RegWriteM_o, stall_o); end
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      checks++;
      if (misalign_o !== 1'b0 || stall_o !== 1'b0 || RegWriteM_o !== 1'b1)
        begin errors++; $display("FAIL misalign_after %0d: mis=%b stall=%b rwo=%b expected 0 0 1", i, misalign_o, stall_o, RegWriteM_o); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_timeout(input bit viaReq);
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemSizeM = 2'd2; ALUDataM = 32'h300;
    for (int c = 0; c <= 6; c++) begin
      bus.mem_gnt = !viaReq && c == 0;
      if (c == 6) clear_inputs();
      @(negedge clk);
      checks++;
      if (bus_err_o !== (c == 4) || stall_o !== (c < 5) || RegWriteM_o !== (c == 6) ||
          bus.mem_req !== (viaReq ? c < 5 : c == 0))
        begin errors++; $display("FAIL timeout_%s cycle %0d: err=%b stall=%b rwo=%b req=%b expected err=%b stall=%b rwo=%b req=%b",
          viaReq ? "req" : "wait", c, bus_err_o, stall_o, RegWriteM_o, bus.mem_req, c == 4, c < 5, c == 6,
          viaReq ? c < 5 : c == 0); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_mid();
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemSizeM = 2'd2; ALUDataM = 32'h400;
    bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b1 || bus.mem_req !== 1'b0)
      begin errors++; $display("FAIL reset_mid_wait: stall=%b req=%b expected 1 0", stall_o, bus.mem_req); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || bus.mem_req !== 1'b0 || RegWriteM_o !== 1'b0)
      begin errors++; $display("FAIL reset_mid_async: stall=%b req=%b rwo=%b expected 0 0 0", stall_o, bus.mem_req, RegWriteM_o); end
    @(posedge clk); #1;
    clear_inputs();
    ALUDataM = 32'h5555_AAAA;
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b0 || WriteRegData !== 32'h5555_AAAA || RegWriteM_o !== 1'b1)
        begin errors++; $display("FAIL reset_mid_rvalid %0d: stall=%b wrd=%h rwo=%b expected 0 5555aaaa 1", c, stall_o, WriteRegData, RegWriteM_o); end
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
    end
  endtask
  task automatic test_random();
    logic [1:0]  size;
    logic [31:0] addr, got;
    bit          load;
    for (int i = 0; i < 60; i++) begin
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << size) - 1);
      load = 1'($urandom);
      if (model_bad(size, addr)) begin
        RegWriteM = 1'b1; MemtoRegM = load; MemWriteM = !load; MemSizeM = size; ALUDataM = addr;
        @(negedge clk);
        checks++;
        if (misalign_o !== 1'b1 || bus.mem_req !== 1'b0 || stall_o !== 1'b0 || RegWriteM_o !== 1'b0)
          begin errors++; $display("FAIL random_bad %0d: size=%0d addr=%h mis=%b req=%b stall=%b rwo=%b expected 1 0 0 0",
            i, size, addr, misalign_o, bus.mem_req, stall_o, RegWriteM_o); end
        @(posedge clk); #1;
        clear_inputs();
      end else
        run_access(load, size, 1'($urandom), 1'($urandom), addr, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), got);
    end
  endtask
  initial begin
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    #1;
    test_reset();
    test_passthrough();
    test_store_byte();
    test_load_half();
    test_misalign();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Parametrised MIPS-style memory stage. Successor to the single-cycle pass-through MEM stage.
- Adds byte, halfword, word and doubleword access sizes, byte enables, load sign/zero extension and misalignment detection.
- Adds a req/gnt/rvalid handshake to a multi-cycle data memory, with a pipeline stall output and a wait timeout.
- Sits between EX/MEM pipeline register and MEM/WB register.

Parameters:
- DATA_W, 32, data path width; legal values 32 or 64.
- ADDR_W, 32, memory address width (low ADDR_W bits of ALUDataM).
- REG_AW, 5, register-file address width.
- MAX_WAIT, 15, cycles allowed in any wait state before bus error; 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- RegWriteM  in  1  instruction writes register file.
- MemtoRegM  in  1  instruction is a load.
- MemWriteM  in  1  instruction is a store.
- MemSizeM  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64).
- MemSignedM  in  1  load sign-extends (1) or zero-extends (0).
- ALUDataM  in  DATA_W  effective address / ALU result.
- WriteDataM  in  DATA_W  store data, right-justified.
- WriteRegM  in  REG_AW  destination register.
- mem_req  out  1  memory request.
- mem_addr  out  ADDR_W  request address, aligned down to DATA_W/8 bytes.
- mem_we  out  1  request is a write.
- mem_be  out  DATA_W/8  byte enables.
- mem_wd  out  DATA_W  store data replicated into lane position.
- mem_gnt  in  1  memory accepted request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data, full aligned word.
- stall_o  out  1  hold all upstream pipeline registers.
- misalign_o  out  1  address not aligned to size, or illegal size; one-cycle flag.
- bus_err_o  out  1  timeout; one-cycle pulse.
- RegWriteM_o  out  1  register write enable to WB.
- WriteRegData  out  DATA_W  write-back data.
- WriteRegAddr  out  REG_AW  = WriteRegM.

Behaviour:
- access = MemtoRegM | MemWriteM.
- Bad access, any of:
  - illegal size;
  - half with addr[0]≠0;
  - word with addr[1:0]≠0;
  - dword with addr[2:0]≠0.
- Byte offset off = addr[log2(DATA_W/8)-1:0].
- mem_be:
  - byte: one bit at off;
  - half: 2 bits at off;
  - word: 4 bits at off;
  - dword: all bits set.
- mem_wd is WriteDataM shifted left by 8*off, lower lanes replicated.
- Load extract: mem_rdata lanes at off, then sign- or zero-extended to DATA_W.
- FSM states IDLE, REQ, WAIT_R, FIN; reset enters IDLE.
- Reset values: state IDLE, wait counter 0, rdata_q 0, bus_err_o 0.
- While rst_n is low, mem_req, stall_o, misalign_o and RegWriteM_o are 0.
- IDLE, no access:
  - pass-through, zero latency, stall_o=0;
  - WriteRegData=ALUDataM, RegWriteM_o=RegWriteM.
- IDLE, bad access:
  - no request, stall_o=0, misalign_o=1;
  - RegWriteM_o=0; store suppressed.
- IDLE, good access:
  - mem_req=1 and stall_o=1, combinationally.
  - On mem_gnt the next state is WAIT_R for a load, FIN for a store.
  - Without mem_gnt the next state is REQ.
- REQ:
  - mem_req=1 with address, be and data held stable; stall_o=1.
  - On mem_gnt the next state is WAIT_R (load) or FIN (store).
- WAIT_R:
  - mem_req=0, stall_o=1.
  - On mem_rvalid, capture the extended load into rdata_q and go to FIN.
  - mem_rvalid in any other state is ignored.
- FIN:
  - stall_o=0.
  - Load: WriteRegData=rdata_q, RegWriteM_o=RegWriteM.
  - Store: RegWriteM_o=0.
  - Next state IDLE; the pipeline advances at the end of FIN.
- Minimum latencies:
  - store: 2 cycles (IDLE with gnt, then FIN);
  - load: 3 cycles (gnt, rvalid, FIN).
- Timeout:
  - The wait counter clears on entering REQ or WAIT_R and increments each cycle in those states.
  - At count=MAX_WAIT with no gnt/rvalid: bus_err_o=1 for one cycle, go to FIN with RegWriteM_o=0, mem_req drops.
- mem_gnt and mem_rvalid in the same cycle while in REQ: gnt is taken, rvalid is ignored.
- An async reset mid-transaction abandons it; the memory is expected to be reset too.

Test Plan:
- ALU op, RegWriteM=1, ALUDataM=0x1234 -> same cycle WriteRegData=0x1234, RegWriteM_o=1, stall_o=0, mem_req=0.
- Store byte, addr 0x103, data 0xAB, gnt in same cycle -> mem_be=1000, mem_wd=0xABxxxxxx, mem_addr=0x100; stall_o high 1 cycle; RegWriteM_o=0 in FIN.
- Signed half load, addr 0x202, rdata 0x8001_0000, gnt after 2 cycles, rvalid after 3 -> WriteRegData=0xFFFF8001 in FIN; unsigned variant gives 0x00008001.
- Word load at addr 0x101 -> misalign_o=1, mem_req=0, RegWriteM_o=0, stall_o=0.
- MAX_WAIT=4, load granted, rvalid never arrives -> bus_err_o pulses on 4th WAIT_R cycle, FIN with RegWriteM_o=0, back to IDLE.
- rst_n low while in WAIT_R -> immediately state IDLE, stall_o=0, mem_req=0; a later rvalid is ignored.
